// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: opcodes, FSM
// states, datapath select codes and the bundled control-output vector.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_I_TYPE = 7'b0010011;
  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_BR     = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC_R,
    S_EXEC_I,
    S_ALUWB,
    S_BRANCH,
    S_JALR_ADR,
    S_JAL,
    S_ILLEGAL
  } state_t;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MDR    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_out_t;

endpackage

// File: rtl/multicycle_controller_decode.sv
// Combinational Moore output decode; FETCH is the only state whose outputs
// also look at mem_ready, so IR/PC load exactly on the completing cycle.
module ctrl_out_decode
  import riscv_ctrl_pkg::*;
(
  input  state_t    state_i,
  input  logic      mem_ready_i,
  output ctrl_out_t out_o
);

  always_comb begin
    out_o = '0;
    unique case (state_i)
      S_FETCH: begin
        out_o.mem_req    = 1'b1;
        out_o.alu_src_a  = SRCA_PC;
        out_o.alu_src_b  = SRCB_FOUR;
        out_o.alu_op     = ALUOP_ADD;
        out_o.result_src = RES_ALU;
        out_o.ir_write   = mem_ready_i;
        out_o.pc_write   = mem_ready_i;
      end
      // Precompute the branch/JAL target while the register file is read.
      S_DECODE: begin
        out_o.alu_src_a = SRCA_OLDPC;
        out_o.alu_src_b = SRCB_IMM;
        out_o.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_JALR_ADR: begin
        out_o.alu_src_a = SRCA_RS1;
        out_o.alu_src_b = SRCB_IMM;
        out_o.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        out_o.mem_req = 1'b1;
        out_o.adr_src = 1'b1;
      end
      S_MEMWB: begin
        out_o.reg_write  = 1'b1;
        out_o.result_src = RES_MDR;
      end
      S_MEMWR: begin
        out_o.mem_req = 1'b1;
        out_o.mem_we  = 1'b1;
        out_o.adr_src = 1'b1;
      end
      S_EXEC_R: begin
        out_o.alu_src_a = SRCA_RS1;
        out_o.alu_src_b = SRCB_RS2;
        out_o.alu_op    = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        out_o.alu_src_a = SRCA_RS1;
        out_o.alu_src_b = SRCB_IMM;
        out_o.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        out_o.reg_write  = 1'b1;
        out_o.result_src = RES_ALUOUT;
      end
      S_BRANCH: begin
        out_o.alu_src_a  = SRCA_RS1;
        out_o.alu_src_b  = SRCB_RS2;
        out_o.alu_op     = ALUOP_BRANCH;
        out_o.branch     = 1'b1;
        out_o.result_src = RES_ALUOUT;
      end
      // PC takes the target from ALUOut while the ALU forms the link value.
      S_JAL: begin
        out_o.pc_write   = 1'b1;
        out_o.result_src = RES_ALUOUT;
        out_o.alu_src_a  = SRCA_OLDPC;
        out_o.alu_src_b  = SRCB_FOUR;
        out_o.alu_op     = ALUOP_ADD;
      end
      S_ILLEGAL: begin
        out_o.illegal = 1'b1;
      end
      default: begin
        out_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multi-cycle RV32I datapath; holds the state register
// and next-state logic, with outputs forced low whenever reset is asserted.
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       branch,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] alu_op,
  output logic       illegal
);

  state_t    state_q, state_d;
  ctrl_out_t dec_out, ctrl;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        unique case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R_TYPE:    state_d = S_EXEC_R;
          OP_I_TYPE:    state_d = S_EXEC_I;
          OP_BR:        state_d = S_BRANCH;
          OP_JAL:       state_d = S_JAL;
          OP_JALR:      state_d = S_JALR_ADR;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      // Only loads and stores reach MEMADR, so anything but LW is a store.
      S_MEMADR:   state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWR:    if (mem_ready) state_d = S_FETCH;
      S_EXEC_R:   state_d = S_ALUWB;
      S_EXEC_I:   state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JALR_ADR: state_d = S_JAL;
      S_JAL:      state_d = S_ALUWB;
      S_ILLEGAL:  state_d = S_ILLEGAL;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  ctrl_out_decode u_decode (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .out_o       (dec_out)
  );

  // Gating here guarantees no request or write enable leaks during reset.
  assign ctrl = reset ? '0 : dec_out;

  assign mem_req    = ctrl.mem_req;
  assign mem_we     = ctrl.mem_we;
  assign adr_src    = ctrl.adr_src;
  assign ir_write   = ctrl.ir_write;
  assign pc_write   = ctrl.pc_write;
  assign branch     = ctrl.branch;
  assign reg_write  = ctrl.reg_write;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign result_src = ctrl.result_src;
  assign alu_op     = ctrl.alu_op;
  assign illegal    = ctrl.illegal;

endmodule
